// File: rtl/iq_dac_sequencer.sv
// Stepped-sine DAC sequencer: divided phase counter driving a one-hot DAC level
// select plus square I/Q reference clocks (Q lags I by a quarter period).
module iq_dac_sequencer #(
    parameter int PHASE_BITS = 3,
    parameter int DIV_BITS   = 4,
    parameter int ALIGN_EN   = 0
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [DIV_BITS-1:0]     Div,
    input  logic                    DacEnable,
    input  logic                    Sync,
    output logic [2**(PHASE_BITS-1):0] DacSel,
    output logic                    IP,
    output logic                    IN,
    output logic                    QP,
    output logic                    QN,
    output logic                    PeriodTick,
    output logic                    EnActive
);

    localparam int HB   = PHASE_BITS - 1;         // width of the half-period index
    localparam int M    = 2**(PHASE_BITS - 2);    // peak level magnitude
    localparam int SELW = 2*M + 1;

    logic [PHASE_BITS-1:0] r_phase;
    logic [DIV_BITS-1:0]   r_div_cnt;
    logic                  r_en_eff;
    logic                  r_wrap;

    logic                  w_step;
    logic                  w_wrap_step;
    logic                  w_s;
    logic [HB-1:0]         w_h;
    logic [HB:0]           w_rise;
    logic [HB:0]           w_fall;
    logic [HB:0]           w_mag;
    logic [SELW-1:0]       w_sel;
    logic [PHASE_BITS-1:0] w_q_phase;

    // >= rather than == so a Div lowered below the running count steps at once.
    assign w_step      = (r_div_cnt >= Div);
    assign w_wrap_step = w_step && (&r_phase);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_phase   <= '0;
            r_div_cnt <= '0;
            r_en_eff  <= 1'b0;
            r_wrap    <= 1'b0;
        end else if (Sync) begin
            r_phase   <= '0;
            r_div_cnt <= '0;
            r_en_eff  <= DacEnable;
            r_wrap    <= 1'b0;
        end else begin
            r_wrap <= w_wrap_step;
            if (w_step) begin
                r_div_cnt <= '0;
                r_phase   <= r_phase + PHASE_BITS'(1);
                if (ALIGN_EN == 0 || w_wrap_step)
                    r_en_eff <= DacEnable;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_BITS'(1);
            end
        end
    end

    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        w_sel     = SELW'(1);
        w_s       = r_phase[PHASE_BITS-1];
        w_h       = r_phase[HB-1:0];
        w_rise    = {1'b0, w_h} + (HB+1)'(1);
        w_fall    = {1'b0, ~w_h};                 // ~h == H-1-h within HB bits
        w_mag     = (w_rise < w_fall) ? w_rise : w_fall;
        w_q_phase = r_phase - PHASE_BITS'(M);
        if (r_en_eff && (w_mag != '0)) begin
            if (!w_s)
                w_sel = SELW'(1) << w_mag;
            else
                w_sel = SELW'(1) << (M + int'(w_mag));
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            DacSel     <= SELW'(1);
            IP         <= 1'b1;
            IN         <= 1'b0;
            QP         <= 1'b0;
            QN         <= 1'b1;
            PeriodTick <= 1'b0;
            EnActive   <= 1'b0;
        end else begin
            DacSel     <= w_sel;
            IP         <= ~w_s;
            IN         <= w_s;
            QP         <= ~w_q_phase[PHASE_BITS-1];
            QN         <= w_q_phase[PHASE_BITS-1];
            PeriodTick <= r_wrap & ~Sync;
            EnActive   <= r_en_eff;
        end
    end

endmodule

// File: tb/tb_iq_dac_sequencer.sv
// Bench for iq_dac_sequencer: three configurations driven in parallel and
// compared every clock against a table-based model, plus directed sequences.
module tb_iq_dac_sequencer;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] Div = 4'd0;
    logic       DacEnable = 1'b0;
    logic       Sync = 1'b0;

    logic [4:0] sel_a, sel_b;
    logic [8:0] sel_c;
    logic ip_a, in_a, qp_a, qn_a, tick_a, act_a;
    logic ip_b, in_b, qp_b, qn_b, tick_b, act_b;
    logic ip_c, in_c, qp_c, qn_c, tick_c, act_c;

    always #5 Clk = ~Clk;

    iq_dac_sequencer #(.PHASE_BITS(3), .DIV_BITS(4), .ALIGN_EN(0)) u_a (
        .Clk(Clk), .Reset(Reset), .Div(Div), .DacEnable(DacEnable), .Sync(Sync),
        .DacSel(sel_a), .IP(ip_a), .IN(in_a), .QP(qp_a), .QN(qn_a),
        .PeriodTick(tick_a), .EnActive(act_a));

    iq_dac_sequencer #(.PHASE_BITS(3), .DIV_BITS(4), .ALIGN_EN(1)) u_b (
        .Clk(Clk), .Reset(Reset), .Div(Div), .DacEnable(DacEnable), .Sync(Sync),
        .DacSel(sel_b), .IP(ip_b), .IN(in_b), .QP(qp_b), .QN(qn_b),
        .PeriodTick(tick_b), .EnActive(act_b));

    iq_dac_sequencer #(.PHASE_BITS(4), .DIV_BITS(4), .ALIGN_EN(0)) u_c (
        .Clk(Clk), .Reset(Reset), .Div(Div), .DacEnable(DacEnable), .Sync(Sync),
        .DacSel(sel_c), .IP(ip_c), .IN(in_c), .QP(qp_c), .QN(qn_c),
        .PeriodTick(tick_c), .EnActive(act_c));

    int n_total = 0;
    int n_bad   = 0;

    // Reference sine levels per phase, straight from the step tables.
    int tab8[8]   = '{1, 2, 1, 0, -1, -2, -1, 0};
    int tab16[16] = '{1, 2, 3, 4, 3, 2, 1, 0, -1, -2, -3, -4, -3, -2, -1, 0};

    int m_n[3]     = '{8, 8, 16};
    int m_align[3] = '{0, 1, 0};
    int m_phase[3], m_cnt[3];
    bit m_en[3], m_wrap[3];
    int e_sel[3];
    bit e_ip[3], e_qp[3], e_tick[3], e_act[3];

    typedef struct {
        logic [3:0] div;
        logic       en;
        logic       sync;
        logic [4:0] exp_sel;
    } vec_t;
    vec_t vecs[20];
    int exp_tab[20] = '{1, 2, 4, 2, 1, 8, 16, 8, 1, 2, 4, 2, 1, 8, 16, 8, 1, 2, 1, 1};
    int div_tab[6]  = '{2, 4, 4, 2, 2, 1};
    int c_tab[16]   = '{2, 4, 8, 16, 8, 4, 2, 1, 32, 64, 128, 256, 128, 64, 32, 1};

    int q_tick[$];
    int ip_r, ip_f, qp_r, dbl, off_nonzero, ip_toggles, la, lb, tick_at_lb;
    bit found;
    logic p_ip, p_qp, p_tick;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(logic [8:0] s, logic ip, logic inn, logic qp,
                                         logic qn, logic tk, logic ac);
        return {17'b0, s, ip, inn, qp, qn, tk, ac};
    endfunction

    function automatic int sel_of(int n, int p, bit en);
        int lv;
        lv = (n == 8) ? tab8[p] : tab16[p];
        if (!en || lv == 0) return 1;
        if (lv > 0) return 1 << lv;
        return 1 << (n / 4 - lv);
    endfunction

    // Advance the model by one clock using the inputs presented before the edge.
    task automatic model_clock();
        for (int k = 0; k < 3; k++) begin
            int n;
            n = m_n[k];
            if (Reset) begin
                e_sel[k] = 1; e_ip[k] = 1; e_qp[k] = 0; e_tick[k] = 0; e_act[k] = 0;
                m_phase[k] = 0; m_cnt[k] = 0; m_en[k] = 0; m_wrap[k] = 0;
            end else begin
                e_sel[k]  = sel_of(n, m_phase[k], m_en[k]);
                e_ip[k]   = (m_phase[k] < n / 2);
                e_qp[k]   = (m_phase[k] >= n / 4) && (m_phase[k] < 3 * n / 4);
                e_tick[k] = m_wrap[k] && !Sync;
                e_act[k]  = m_en[k];
                if (Sync) begin
                    m_phase[k] = 0; m_cnt[k] = 0; m_en[k] = DacEnable; m_wrap[k] = 0;
                end else if (m_cnt[k] >= int'(Div)) begin
                    m_wrap[k]  = (m_phase[k] == n - 1);
                    m_phase[k] = (m_phase[k] + 1) % n;
                    m_cnt[k]   = 0;
                    if (m_align[k] == 0 || m_wrap[k]) m_en[k] = DacEnable;
                end else begin
                    m_cnt[k]++;
                    m_wrap[k] = 0;
                end
            end
        end
    endtask

    function automatic logic [31:0] pack_exp(int k);
        return pack(9'(e_sel[k]), e_ip[k], !e_ip[k], e_qp[k], !e_qp[k], e_tick[k], e_act[k]);
    endfunction

    task automatic compare_all();
        check("out_a", pack(9'(sel_a), ip_a, in_a, qp_a, qn_a, tick_a, act_a), pack_exp(0));
        check("out_b", pack(9'(sel_b), ip_b, in_b, qp_b, qn_b, tick_b, act_b), pack_exp(1));
        check("out_c", pack(sel_c, ip_c, in_c, qp_c, qn_c, tick_c, act_c), pack_exp(2));
        check("onehot_a", 32'($onehot(sel_a)), 32'd1);
        check("onehot_c", 32'($onehot(sel_c)), 32'd1);
    endtask

    task automatic cycle();
        model_clock();
        @(posedge Clk);
        #1;
        compare_all();
    endtask

    initial begin
        for (int i = 0; i < 20; i++)
            vecs[i] = '{div: 4'd0, en: (i < 17), sync: (i == 0), exp_sel: 5'(exp_tab[i])};

        // Reset state
        Reset = 1'b1;
        cycle();
        cycle();
        check("reset_sel", 32'(sel_a), 32'd1);
        Reset = 1'b0;

        // Sync-started sequence then disable, table driven
        for (int i = 0; i < 20; i++) begin
            Div = vecs[i].div; DacEnable = vecs[i].en; Sync = vecs[i].sync;
            cycle();
            check($sformatf("vec%0d", i), 32'(sel_a), 32'(vecs[i].exp_sel));
        end
        Sync = 1'b0;

        // Div=3: tick period, IP width, QP offset
        Div = 4'd3; DacEnable = 1'b1; Sync = 1'b1;
        cycle();
        Sync = 1'b0;
        ip_r = -1; ip_f = -1; qp_r = -1; dbl = 0;
        p_ip = ip_a; p_qp = qp_a; p_tick = tick_a;
        for (int i = 0; i < 120; i++) begin
            cycle();
            if (tick_a) begin q_tick.push_back(i); if (p_tick) dbl++; end
            if (ip_a && !p_ip && ip_r < 0) ip_r = i;
            if (!ip_a && p_ip && ip_r >= 0 && ip_f < 0) ip_f = i;
            if (qp_a && !p_qp && ip_r >= 0 && qp_r < 0) qp_r = i;
            p_ip = ip_a; p_qp = qp_a; p_tick = tick_a;
        end
        check("tick_period", (q_tick.size() >= 2) ? 32'(q_tick[1] - q_tick[0]) : 32'hffff_ffff, 32'd32);
        check("tick_width", 32'(dbl), 32'd0);
        check("ip_high_len", 32'(ip_f - ip_r), 32'd16);
        check("qp_lag", 32'(qp_r - ip_r), 32'd8);

        // Disabled DAC, then enable mid-period
        DacEnable = 1'b0; Sync = 1'b1;
        cycle();
        Sync = 1'b0;
        off_nonzero = 0; ip_toggles = 0; p_ip = ip_a;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (sel_a != 5'd1 || sel_b != 5'd1) off_nonzero++;
            if (ip_a != p_ip) ip_toggles++;
            p_ip = ip_a;
        end
        check("off_sel_zero", 32'(off_nonzero), 32'd0);
        check("off_ip_toggles", 32'(ip_toggles >= 2), 32'd1);
        DacEnable = 1'b1;
        la = -1; lb = -1; tick_at_lb = 0;
        for (int i = 0; i < 64; i++) begin
            cycle();
            if (act_a && la < 0) la = i;
            if (act_b && lb < 0) begin lb = i; tick_at_lb = int'(tick_b); end
        end
        check("align0_latency", 32'(la), 32'd4);
        check("align1_latency", 32'(lb), 32'd24);
        check("align1_at_wrap", 32'(tick_at_lb), 32'd1);

        // Sync at phase 5, Div=2
        Div = 4'd2; found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            if (m_phase[0] == 5) found = 1;
        end
        check("sync_phase5_found", 32'(found), 32'd1);
        Sync = 1'b1;
        cycle();
        check("sync_edge_tick", 32'(tick_a), 32'd0);
        Sync = 1'b0;
        cycle();
        check("sync_after", {29'b0, ip_a, qp_a, tick_a}, 32'b100);

        // Div lowered 15 -> 1 with DivCnt at 10
        Div = 4'd15; DacEnable = 1'b1; Sync = 1'b1;
        cycle();
        Sync = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        Div = 4'd1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check($sformatf("div_drop%0d", i), 32'(sel_a), 32'(div_tab[i]));
        end

        // 16-step configuration levels
        Div = 4'd0; Sync = 1'b1;
        cycle();
        Sync = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            check($sformatf("n16_lvl%0d", i), 32'(sel_c), 32'(c_tab[i]));
        end

        // Reset mid-period
        for (int i = 0; i < 5; i++) cycle();
        Reset = 1'b1;
        cycle();
        check("midreset_a", pack(9'(sel_a), ip_a, in_a, qp_a, qn_a, tick_a, act_a),
              pack(9'd1, 1, 0, 0, 1, 0, 0));
        check("midreset_c", pack(sel_c, ip_c, in_c, qp_c, qn_c, tick_c, act_c),
              pack(9'd1, 1, 0, 0, 1, 0, 0));
        Reset = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            Reset = ($urandom_range(0, 199) == 0);
            Sync  = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 19) == 0)
                Div = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) DacEnable = ~DacEnable;
            cycle();
        end
        Reset = 1'b0; Sync = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
